// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: operand/shift widths, opcode encoding and the
// result bundle produced by the ALU.
package alu_arbiter_pkg;

   localparam int XLEN = 32;
   localparam int SHW  = 5;
   localparam int OPW  = 5;

   typedef enum logic [OPW-1:0] {
      OP_ADD = 5'd0,
      OP_SUB = 5'd1,
      OP_AND = 5'd2,
      OP_OR  = 5'd3,
      OP_SLL = 5'd4,
      OP_SRA = 5'd5
   } alu_op_e;

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic            ne;
      logic            lt;
      logic            ovf;
      logic            err;
   } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters. Illegal opcodes yield an
// all-zero result bundle with only err set.
module alu
   import alu_arbiter_pkg::*;
(
   input  logic [OPW-1:0]  opcode,
   input  logic [SHW-1:0]  shamt,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output alu_rsp_t        rsp
);

   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] diff;

   assign sum  = a + b;
   assign diff = a - b;

   always_comb begin
      rsp        = '0;
      rsp.ne     = (a != b);
      rsp.lt     = ($signed(a) < $signed(b));
      case (alu_op_e'(opcode))
         OP_ADD: begin
            rsp.result = sum;
            rsp.ovf    = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
         end
         OP_SUB: begin
            rsp.result = diff;
            rsp.ovf    = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
         end
         OP_AND:  rsp.result = a & b;
         OP_OR:   rsp.result = a | b;
         OP_SLL:  rsp.result = a << shamt;
         OP_SRA:  rsp.result = $signed(a) >>> shamt;
         default: begin
            rsp     = '0;
            rsp.err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: grant selection, operand mux
// and a single-entry response register with valid/ready back-pressure.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [OPW-1:0]  req0_opcode,
   input  logic [SHW-1:0]  req0_shamt,
   input  logic [XLEN-1:0] req0_a,
   input  logic [XLEN-1:0] req0_b,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [OPW-1:0]  req1_opcode,
   input  logic [SHW-1:0]  req1_shamt,
   input  logic [XLEN-1:0] req1_a,
   input  logic [XLEN-1:0] req1_b,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic [XLEN-1:0] rsp_result,
   output logic            rsp_ne,
   output logic            rsp_lt,
   output logic            rsp_ovf,
   output logic            rsp_err
);

   logic            run_reg;
   logic            last_reg;
   logic            rsp_valid_reg;
   logic            rsp_id_reg;
   alu_rsp_t        rsp_reg;

   logic            grant;
   logic            accept;
   logic [OPW-1:0]  sel_opcode;
   logic [SHW-1:0]  sel_shamt;
   logic [XLEN-1:0] sel_a;
   logic [XLEN-1:0] sel_b;
   alu_rsp_t        alu_out;

   // run_reg keeps readies low while reset is asserted and until the first
   // clock edge after release.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = FIXED_PRIO ? 1'b0 : ~last_reg;
      end else begin
         grant = req1_valid;
      end
      accept = run_reg && (!rsp_valid_reg || rsp_ready) && (req0_valid || req1_valid);
   end

   assign req0_ready = accept & ~grant;
   assign req1_ready = accept &  grant;

   assign sel_opcode = grant ? req1_opcode : req0_opcode;
   assign sel_shamt  = grant ? req1_shamt  : req0_shamt;
   assign sel_a      = grant ? req1_a      : req0_a;
   assign sel_b      = grant ? req1_b      : req0_b;

   alu u_alu (
      .opcode (sel_opcode),
      .shamt  (sel_shamt),
      .a      (sel_a),
      .b      (sel_b),
      .rsp    (alu_out)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         run_reg       <= 1'b0;
         last_reg      <= 1'b1;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= 1'b0;
         rsp_reg       <= '0;
      end else begin
         run_reg <= 1'b1;
         if (accept) begin
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= grant;
            rsp_reg       <= alu_out;
            last_reg      <= grant;
         end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
         end
      end
   end

   assign rsp_valid  = rsp_valid_reg;
   assign rsp_id     = rsp_id_reg;
   assign rsp_result = rsp_reg.result;
   assign rsp_ne     = rsp_reg.ne;
   assign rsp_lt     = rsp_reg.lt;
   assign rsp_ovf    = rsp_reg.ovf;
   assign rsp_err    = rsp_reg.err;

endmodule
